wb_result_collector: RTL and testbench
======================================

// Module: wb_result_collector
// PURPOSE
//  Consumer end of the execute-stage result interface. Takes the un-backpressured
//  writeback channels (FLU, load, store, FPU; each a single-cycle valid with
//  trans_id/result/exception) and buffers each in a small per-channel FIFO.
//  Merges the channels round-robin onto one valid/ready scoreboard write port.
//  Returns per-channel almost-full so issue can stall a unit before its FIFO overflows.
// PARAMETERS
//  NR_PORTS  4  input result channels (0=FLU,1=load,2=store,3=FPU); >=2
//  DEPTH     2  entries per channel FIFO; power of 2, >=2
//  (TRANS_ID_BITS and exception_t come from ariane_pkg)
// PORTS
//  clk_i             in   1                       clock
//  rst_ni            in   1                       async reset, active low
//  flush_i           in   1                       drop all buffered results
//  res_valid_i       in   NR_PORTS                per-channel result valid (no ready)
//  res_trans_id_i    in   NR_PORTS*TRANS_ID_BITS  per-channel scoreboard id
//  res_result_i      in   NR_PORTS*64             per-channel result
//  res_exception_i   in   NR_PORTS*exception_t    per-channel exception
//  ch_almost_full_o  out  NR_PORTS                count >= DEPTH-1
//  wb_valid_o        out  1                       writeback entry available
//  wb_ready_i        in   1                       scoreboard accepts
//  wb_trans_id_o     out  TRANS_ID_BITS           writeback id
//  wb_result_o       out  64                      writeback data
//  wb_exception_o    out  exception_t             writeback exception
//  wb_port_o         out  $clog2(NR_PORTS)        source channel of current entry
//  overflow_o        out  1                       sticky: a push was dropped
// BEHAVIOUR
//  Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
//  Reset values: all FIFOs empty, rr pointer=0, grant unlocked. Outputs:
//   wb_valid_o=0, ch_almost_full_o=0, overflow_o=0, wb_port_o=0.
//   wb_trans_id_o, wb_result_o and wb_exception_o drive 0 whenever wb_valid_o=0.
//  Push:
//   - res_valid_i[c] writes channel c's FIFO tail on the clock edge.
//   - Minimum latency is 1 cycle: input valid in cycle N gives wb_valid_o in N+1.
//   - There is no combinational bypass.
//  Arbitration:
//   - When unlocked, grant goes to the first non-empty channel at or after rr, wrapping.
//   - Output is driven combinationally from the granted FIFO head.
//  Lock:
//   - If wb_valid_o=1 and wb_ready_i=0, the grant locks.
//   - Output must stay stable, bit-for-bit, until the handshake.
//  Pop:
//   - On a handshake (wb_valid_o & wb_ready_i), the head of the granted channel pops.
//   - rr becomes (granted+1) mod NR_PORTS and the grant unlocks.
//   - Throughput is 1 result/cycle.
//  Simultaneous push and pop on one channel:
//   - Allowed at any occupancy, including full; count is unchanged.
//   - The entry pushed in that cycle is not visible at the head in the same cycle.
//  Overflow:
//   - Condition: push to a full channel with no pop from it that cycle.
//   - The new entry is dropped and FIFO contents are unchanged.
//   - overflow_o is set and stays set until reset; flush does not clear it.
//   - Issue must honour ch_almost_full_o, so overflow indicates a design bug.
//  Count: width $clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
//  Flush (flush_i=1):
//   - Next cycle: all counts=0, pointers=0, rr=0, grant unlocked.
//   - Pushes in the flush cycle are discarded.
//   - A handshake in the flush cycle still completes on the port, but its entry is gone after flush.
//   - wb_valid_o=0 in the cycle after flush.
//  Exception field: carried unmodified; a valid exception does not alter ordering.
//  Ordering: FIFO order within a channel; no ordering guarantee across channels.
// TESTING
//  1) Single push: ch1 valid, id=3, result=0xDEAD, wb_ready_i=1
//     -> next cycle wb_valid_o=1, id=3, result=0xDEAD, port=1; then wb_valid_o=0.
//  2) Round-robin: all 4 channels push ids 0..3 in one cycle, ready=1
//     -> ids 0,1,2,3 on consecutive cycles.
//     -> A second simultaneous burst then drains starting at rr=0.
//  3) Backpressure: ch2 holds id=5, ch0 pushes id=6 while ready=0 for 3 cycles
//     -> id=5/port=2 held stable for all 3 cycles; then id=6 follows.
//  4) Full and overflow, DEPTH=2, ready=0:
//     -> 1 push: almost_full=1.
//     -> 2 pushes: full, no overflow.
//     -> 3rd push: overflow_o=1, and the drained data is only the first two ids.
//  5) Push+pop when full: ch0 full, ready=1, ch0 pushes each cycle
//     -> no overflow, one result/cycle, FIFO order preserved.
//  6) Flush with 3 channels buffered
//     -> wb_valid_o=0 next cycle, almost_full=0.
//     -> Pushes in the flush cycle never appear.
//  7) Reset asserted mid-drain
//     -> all outputs are at reset values immediately (asynchronously), and remain so after release.

Source files
------------

// File: rtl/wb_result_collector.sv
// rtl/wb_result_collector.sv - per-channel writeback FIFOs merged round-robin onto one valid/ready port

module wb_result_collector #(
    parameter int NR_PORTS      = 4,
    parameter int DEPTH         = 2,
    parameter int TRANS_ID_BITS = 3,
    parameter int EXC_BITS      = 129
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [NR_PORTS-1:0]               res_valid_i,
    input  logic [NR_PORTS*TRANS_ID_BITS-1:0] res_trans_id_i,
    input  logic [NR_PORTS*64-1:0]            res_result_i,
    input  logic [NR_PORTS*EXC_BITS-1:0]      res_exception_i,
    output logic [NR_PORTS-1:0]               ch_almost_full_o,
    output logic                              wb_valid_o,
    input  logic                              wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]          wb_trans_id_o,
    output logic [63:0]                       wb_result_o,
    output logic [EXC_BITS-1:0]               wb_exception_o,
    output logic [$clog2(NR_PORTS)-1:0]       wb_port_o,
    output logic                              overflow_o
);

    localparam int PORT_W  = $clog2(NR_PORTS);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = EXC_BITS + 64 + TRANS_ID_BITS;

    logic [NR_PORTS-1:0]              non_empty;
    logic [NR_PORTS-1:0]              drop;
    logic [NR_PORTS-1:0][ENTRY_W-1:0] head_ch;

    logic [PORT_W-1:0] rr_q;
    logic [PORT_W-1:0] lock_port_q;
    logic              locked_q;
    logic              overflow_q;
    logic [PORT_W-1:0] gnt;
    logic              found;
    logic              handshake;

    for (genvar c = 0; c < NR_PORTS; c++) begin : g_ch
        logic [ENTRY_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]   rptr_q;
        logic [PTR_W-1:0]   wptr_q;
        logic [CNT_W-1:0]   cnt_q;
        logic               push;
        logic               pop;
        logic               full;
        logic               push_ok;
        logic [ENTRY_W-1:0] entry_in;

        assign push     = res_valid_i[c] & ~flush_i;
        assign pop      = handshake && (gnt == PORT_W'(c));
        assign full     = (cnt_q == CNT_W'(DEPTH));
        // A pop frees the head slot in the same edge, so a full FIFO still accepts.
        assign push_ok  = push & (~full | pop);
        assign entry_in = {res_exception_i[c*EXC_BITS +: EXC_BITS],
                           res_result_i[c*64 +: 64],
                           res_trans_id_i[c*TRANS_ID_BITS +: TRANS_ID_BITS]};

        assign non_empty[c]        = (cnt_q != '0);
        assign drop[c]             = push & full & ~pop;
        assign head_ch[c]          = mem_q[rptr_q];
        assign ch_almost_full_o[c] = (cnt_q >= CNT_W'(DEPTH - 1));

        always_ff @(posedge clk_i) begin
            if (push_ok) begin
                mem_q[wptr_q] <= entry_in;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rptr_q <= '0;
                wptr_q <= '0;
                cnt_q  <= '0;
            end else if (flush_i) begin
                rptr_q <= '0;
                wptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push_ok) begin
                    wptr_q <= wptr_q + 1'b1;
                end
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                if (push_ok && !pop) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (!push_ok && pop) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        int idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        if (locked_q) begin
            gnt   = lock_port_q;
            found = 1'b1;
        end else begin
            for (int i = 0; i < NR_PORTS; i++) begin
                idx = (int'(rr_q) + i) % NR_PORTS;
                if (!found && non_empty[idx[PORT_W-1:0]]) begin
                    gnt   = idx[PORT_W-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    assign handshake  = found & wb_ready_i;
    assign wb_valid_o = found;
    assign overflow_o = overflow_q;

    always_comb begin
        wb_trans_id_o  = '0;
        wb_result_o    = '0;
        wb_exception_o = '0;
        wb_port_o      = '0;
        if (found) begin
            {wb_exception_o, wb_result_o, wb_trans_id_o} = head_ch[gnt];
            wb_port_o = gnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            lock_port_q <= '0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_q | (|drop);
            if (flush_i) begin
                rr_q     <= '0;
                locked_q <= 1'b0;
            end else if (handshake) begin
                rr_q     <= (gnt == PORT_W'(NR_PORTS - 1)) ? '0 : gnt + 1'b1;
                locked_q <= 1'b0;
            end else if (found) begin
                // Hold the offered entry until the scoreboard takes it.
                lock_port_q <= gnt;
                locked_q    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_result_collector.sv
// tb/tb_wb_result_collector.sv - directed self-checking bench for wb_result_collector

module tb_wb_result_collector;

    localparam int NP  = 4;
    localparam int DP  = 2;
    localparam int TID = 5;
    localparam int EXC = 129;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic [NP-1:0]     res_valid_i;
    logic [NP*TID-1:0] res_trans_id_i;
    logic [NP*64-1:0]  res_result_i;
    logic [NP*EXC-1:0] res_exception_i;
    logic [NP-1:0]     ch_almost_full_o;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [TID-1:0]    wb_trans_id_o;
    logic [63:0]       wb_result_o;
    logic [EXC-1:0]    wb_exception_o;
    logic [1:0]        wb_port_o;
    logic              overflow_o;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_result_collector #(
        .NR_PORTS(NP), .DEPTH(DP), .TRANS_ID_BITS(TID), .EXC_BITS(EXC)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .flush_i(flush_i),
        .res_valid_i(res_valid_i),
        .res_trans_id_i(res_trans_id_i),
        .res_result_i(res_result_i),
        .res_exception_i(res_exception_i),
        .ch_almost_full_o(ch_almost_full_o),
        .wb_valid_o(wb_valid_o),
        .wb_ready_i(wb_ready_i),
        .wb_trans_id_o(wb_trans_id_o),
        .wb_result_o(wb_result_o),
        .wb_exception_o(wb_exception_o),
        .wb_port_o(wb_port_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic set_ch(input int c, input logic [TID-1:0] id, input logic [63:0] res);
        res_valid_i[c]              = 1'b1;
        res_trans_id_i[c*TID +: TID] = id;
        res_result_i[c*64 +: 64]     = res;
        res_exception_i[c*EXC +: EXC] = {id[0], 64'(c), res};
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        res_valid_i = '0;
    endtask

    task automatic test_reset();
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        wb_ready_i      = 1'b0;
        res_valid_i     = '0;
        res_trans_id_i  = '0;
        res_result_i    = '0;
        res_exception_i = '0;
        #2;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h expected 0", wb_valid_o); end
        n_cmp++; if (ch_almost_full_o !== 4'b0000) begin n_fail++; $display("FAIL rst_af: got %0h expected 0", ch_almost_full_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0h expected 0", overflow_o); end
        n_cmp++; if (wb_port_o !== 2'd0) begin n_fail++; $display("FAIL rst_port: got %0h expected 0", wb_port_o); end
        n_cmp++; if (wb_result_o !== 64'd0) begin n_fail++; $display("FAIL rst_result: got %0h expected 0", wb_result_o); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid_after: got %0h expected 0", wb_valid_o); end
    endtask

    task automatic test_single_push();
        wb_ready_i = 1'b1;
        set_ch(1, 5'd3, 64'hDEAD);
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %0h expected 0", wb_valid_o); end
        tick();
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0h expected 1", wb_valid_o); end
        n_cmp++; if (wb_trans_id_o !== 5'd3) begin n_fail++; $display("FAIL single_id: got %0h expected 3", wb_trans_id_o); end
        n_cmp++; if (wb_result_o !== 64'hDEAD) begin n_fail++; $display("FAIL single_result: got %0h expected dead", wb_result_o); end
        n_cmp++; if (wb_port_o !== 2'd1) begin n_fail++; $display("FAIL single_port: got %0h expected 1", wb_port_o); end
        n_cmp++; if (wb_exception_o !== {1'b1, 64'd1, 64'hDEAD}) begin n_fail++; $display("FAIL single_exc: got %0h expected %0h", wb_exception_o, {1'b1, 64'd1, 64'hDEAD}); end
        tick();
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %0h expected 0", wb_valid_o); end
        n_cmp++; if (wb_result_o !== 64'd0) begin n_fail++; $display("FAIL single_zero_result: got %0h expected 0", wb_result_o); end
    endtask

    task automatic test_round_robin();
        logic [TID-1:0] exp_id [8];
        exp_id = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11};
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wb_ready_i = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < NP; c++) set_ch(c, exp_id[b*4+c], 64'h100 + 64'(exp_id[b*4+c]));
            tick();
            for (int k = 0; k < NP; k++) begin
                n_cmp++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== exp_id[b*4+k] || wb_port_o !== 2'(k)) begin n_fail++; $display("FAIL rr_b%0d_k%0d: got v=%0h id=%0h port=%0h expected v=1 id=%0h port=%0h", b, k, wb_valid_o, wb_trans_id_o, wb_port_o, exp_id[b*4+k], k); end
                n_cmp++; if (wb_result_o !== 64'h100 + 64'(exp_id[b*4+k])) begin n_fail++; $display("FAIL rr_result_b%0d_k%0d: got %0h expected %0h", b, k, wb_result_o, 64'h100 + 64'(exp_id[b*4+k])); end
                tick();
            end
            n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_empty_b%0d: got %0h expected 0", b, wb_valid_o); end
        end
    endtask

    task automatic test_backpressure();
        wb_ready_i = 1'b0;
        set_ch(2, 5'd5, 64'h55);
        tick();
        set_ch(0, 5'd6, 64'h66);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 5'd5 || wb_port_o !== 2'd2 || wb_result_o !== 64'h55) begin n_fail++; $display("FAIL bp_hold_%0d: got v=%0h id=%0h port=%0h res=%0h expected v=1 id=5 port=2 res=55", k, wb_valid_o, wb_trans_id_o, wb_port_o, wb_result_o); end
            n_cmp++; if (wb_exception_o !== {1'b1, 64'd2, 64'h55}) begin n_fail++; $display("FAIL bp_exc_%0d: got %0h expected %0h", k, wb_exception_o, {1'b1, 64'd2, 64'h55}); end
            if (k < 2) tick();
        end
        wb_ready_i = 1'b1;
        tick();
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 5'd6 || wb_port_o !== 2'd0) begin n_fail++; $display("FAIL bp_next: got v=%0h id=%0h port=%0h expected v=1 id=6 port=0", wb_valid_o, wb_trans_id_o, wb_port_o); end
        tick();
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0h expected 0", wb_valid_o); end
    endtask

    task automatic test_push_pop_full();
        logic [TID-1:0] exp_id [4];
        exp_id = '{5'd2, 5'd3, 5'd4, 5'd5};
        wb_ready_i = 1'b0;
        set_ch(0, 5'd1, 64'h1);
        tick();
        set_ch(0, 5'd2, 64'h2);
        tick();
        n_cmp++; if (wb_trans_id_o !== 5'd1 || ch_almost_full_o !== 4'b0001) begin n_fail++; $display("FAIL ppf_full: got id=%0h af=%0h expected id=1 af=1", wb_trans_id_o, ch_almost_full_o); end
        wb_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) set_ch(0, 5'd3 + 5'(k), 64'd3 + 64'(k));
            tick();
            n_cmp++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== exp_id[k] || wb_result_o !== 64'(exp_id[k])) begin n_fail++; $display("FAIL ppf_order_%0d: got v=%0h id=%0h res=%0h expected v=1 id=%0h", k, wb_valid_o, wb_trans_id_o, wb_result_o, exp_id[k]); end
            n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ppf_ovf_%0d: got %0h expected 0", k, overflow_o); end
        end
        tick();
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL ppf_empty: got %0h expected 0", wb_valid_o); end
    endtask

    task automatic test_overflow();
        wb_ready_i = 1'b0;
        set_ch(3, 5'd20, 64'h20);
        tick();
        n_cmp++; if (ch_almost_full_o !== 4'b1000 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_one: got af=%0h ovf=%0h expected af=8 ovf=0", ch_almost_full_o, overflow_o); end
        set_ch(3, 5'd21, 64'h21);
        tick();
        n_cmp++; if (ch_almost_full_o !== 4'b1000 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_two: got af=%0h ovf=%0h expected af=8 ovf=0", ch_almost_full_o, overflow_o); end
        set_ch(3, 5'd22, 64'h22);
        tick();
        n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_three: got %0h expected 1", overflow_o); end
        wb_ready_i = 1'b1;
        n_cmp++; if (wb_trans_id_o !== 5'd20 || wb_port_o !== 2'd3) begin n_fail++; $display("FAIL ovf_drain0: got id=%0h port=%0h expected id=14 port=3", wb_trans_id_o, wb_port_o); end
        tick();
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 5'd21) begin n_fail++; $display("FAIL ovf_drain1: got v=%0h id=%0h expected v=1 id=15", wb_valid_o, wb_trans_id_o); end
        tick();
        n_cmp++; if (wb_valid_o !== 1'b0 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_end: got v=%0h ovf=%0h expected v=0 ovf=1", wb_valid_o, overflow_o); end
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        set_ch(0, 5'd10, 64'h10);
        set_ch(1, 5'd11, 64'h11);
        set_ch(2, 5'd12, 64'h12);
        tick();
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 5'd10 || ch_almost_full_o !== 4'b0111) begin n_fail++; $display("FAIL fl_pre: got v=%0h id=%0h af=%0h expected v=1 id=a af=7", wb_valid_o, wb_trans_id_o, ch_almost_full_o); end
        flush_i = 1'b1;
        set_ch(3, 5'd13, 64'h13);
        set_ch(0, 5'd14, 64'h14);
        tick();
        flush_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b0 || ch_almost_full_o !== 4'b0000) begin n_fail++; $display("FAIL fl_post: got v=%0h af=%0h expected v=0 af=0", wb_valid_o, ch_almost_full_o); end
        n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL fl_ovf_sticky: got %0h expected 1", overflow_o); end
        wb_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_no_push_%0d: got %0h expected 0", k, wb_valid_o); end
        end
    endtask

    task automatic test_reset_mid_drain();
        wb_ready_i = 1'b1;
        set_ch(0, 5'd1, 64'h1);
        set_ch(1, 5'd2, 64'h2);
        set_ch(2, 5'd3, 64'h3);
        tick();
        tick();
        n_cmp++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 5'd2) begin n_fail++; $display("FAIL rmd_pre: got v=%0h id=%0h expected v=1 id=2", wb_valid_o, wb_trans_id_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0 || wb_port_o !== 2'd0 || wb_trans_id_o !== 5'd0 || wb_result_o !== 64'd0) begin n_fail++; $display("FAIL rmd_async: got v=%0h port=%0h id=%0h res=%0h expected all 0", wb_valid_o, wb_port_o, wb_trans_id_o, wb_result_o); end
        n_cmp++; if (overflow_o !== 1'b0 || ch_almost_full_o !== 4'b0000) begin n_fail++; $display("FAIL rmd_flags: got ovf=%0h af=%0h expected 0 0", overflow_o, ch_almost_full_o); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (wb_valid_o !== 1'b0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL rmd_after: got v=%0h ovf=%0h expected 0 0", wb_valid_o, overflow_o); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_round_robin();
        test_backpressure();
        test_push_pop_full();
        test_overflow();
        test_flush();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
